// File: rtl/mod_dec_inv_shifter_if.sv
// Byte-serial input, byte-serial/parallel output bus of the decryption InvShiftRows stage.
// The master drives state bytes in and drains results; the slave is the shifter.
interface mod_dec_inv_shifter_if;
  localparam int unsigned N  = 16;
  localparam int unsigned BW = 8;

  logic                 in_valid;
  logic [BW-1:0]        in_byte;
  logic                 in_ready;
  logic                 out_valid;
  logic [BW-1:0]        out_byte;
  logic                 out_ready;
  logic [N-1:0][BW-1:0] out_block;
  logic                 blk_valid;
  logic                 blk_done;

  modport master (
    output in_valid, in_byte, out_ready,
    input  in_ready, out_valid, out_byte, out_block, blk_valid, blk_done
  );

  modport slave (
    input  in_valid, in_byte, out_ready,
    output in_ready, out_valid, out_byte, out_block, blk_valid, blk_done
  );
endinterface

// File: rtl/mod_dec_inv_shifter.sv
// AES decryption InvShiftRows: collects 16 state bytes, rotates rows right by the row index,
// then presents the block in parallel and streams it out byte by byte under backpressure.
module mod_dec_inv_shifter (
  input  logic                 clk,
  input  logic                 reset,
  mod_dec_inv_shifter_if.slave bus
);
  // Block size is fixed at 16 bytes; other sizes are not supported.
  localparam int unsigned N  = 16;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = $clog2(N);

  typedef logic [N-1:0][BW-1:0] block_t;
  typedef enum logic [0:0] {FILL, DRAIN} state_t;

  state_t         state_q, state_d;
  block_t         buf_q, buf_d;
  logic [CW-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]  rd_cnt_q, rd_cnt_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           blk_valid_q, blk_valid_d;
  logic           blk_done_q, blk_done_d;
  logic [BW-1:0]  out_byte_q, out_byte_d;
  block_t         block_q, block_d;

  // Row r of the result takes buffer row r rotated right by r positions.
  function automatic block_t inv_map(input block_t b);
    block_t m;
    m = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        m[4*r + c] = b[4*r + ((c - r + 4) % 4)];
      end
    end
    return m;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    blk_done_d = 1'b0;

    unique case (state_q)
      FILL: begin
        if (bus.in_valid && in_ready_q) begin
          buf_d = {bus.in_byte, buf_q[N-1:1]};
          if (wr_cnt_q == CW'(N-1)) begin
            wr_cnt_d = '0;
            state_d  = DRAIN;
          end else begin
            wr_cnt_d = wr_cnt_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (bus.out_ready && out_valid_q) begin
          if (rd_cnt_q == CW'(N-1)) begin
            rd_cnt_d   = '0;
            state_d    = FILL;
            blk_done_d = 1'b1;
          end else begin
            rd_cnt_d = rd_cnt_q + CW'(1);
          end
        end
      end
    endcase

    // Outputs are registered from next-state values so they line up with the state they describe.
    in_ready_d  = (state_d == FILL);
    out_valid_d = (state_d == DRAIN);
    blk_valid_d = (state_d == DRAIN);
    block_d     = out_valid_d ? inv_map(buf_d) : '0;
    out_byte_d  = block_d[rd_cnt_d];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q       <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      blk_valid_q <= 1'b0;
      blk_done_q  <= 1'b0;
      out_byte_q  <= '0;
      block_q     <= '0;
    end else begin
      buf_q       <= buf_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      blk_valid_q <= blk_valid_d;
      blk_done_q  <= blk_done_d;
      out_byte_q  <= out_byte_d;
      block_q     <= block_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.blk_valid = blk_valid_q;
  assign bus.blk_done  = blk_done_q;
  assign bus.out_byte  = out_byte_q;
  assign bus.out_block = block_q;
endmodule

// File: tb/tb_mod_dec_inv_shifter.sv
// Directed bench for mod_dec_inv_shifter: table of input blocks with hand-computed
// InvShiftRows results, plus reset-abort sequences.
module tb_mod_dec_inv_shifter;
  logic clk;
  logic reset;

  mod_dec_inv_shifter_if bus ();

  mod_dec_inv_shifter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Blocks are written in arrival order: byte k is bits [127-8k -: 8].
  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
    bit           gaps;
    bit           stall;
    bit           junk;
  } vec_t;

  localparam int unsigned NV = 7;
  vec_t vecs [NV];
  int   n_cmp;
  int   n_bad;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0][7:0] to_blk(input logic [127:0] v);
    logic [15:0][7:0] b;
    for (int k = 0; k < 16; k++) b[k] = v[127-8*k -: 8];
    return b;
  endfunction

  task automatic run_vec(input vec_t v);
    int   k;
    int   j;
    int   cyc;
    int   stall_left;
    logic acc;
    k   = 0;
    cyc = 0;
    while (k < 16 && cyc < 300) begin
      bus.in_valid = v.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.in_byte  = v.din[127-8*k -: 8];
      acc = bus.in_valid && bus.in_ready;
      if (acc && k == 15) chk("out_valid_before_last_in", 128'(bus.out_valid), 128'(0));
      @(posedge clk); #1;
      cyc++;
      if (acc) k++;
    end
    if (k < 16) chk("fill_timeout", 128'(k), 128'(16));
    bus.in_valid = v.junk;
    bus.in_byte  = 8'hFF;
    chk("out_valid_latency", 128'(bus.out_valid), 128'(1));
    chk("blk_valid", 128'(bus.blk_valid), 128'(1));
    chk("out_block", bus.out_block, to_blk(v.dout));

    j          = 0;
    cyc        = 0;
    stall_left = 5;
    while (j < 16 && cyc < 300) begin
      if (v.stall && j == 6 && stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = 1'b1;
      end
      chk("drain_out_valid", 128'(bus.out_valid), 128'(1));
      chk("out_byte", 128'(bus.out_byte), 128'(v.dout[127-8*j -: 8]));
      chk("drain_in_ready", 128'(bus.in_ready), 128'(0));
      chk("drain_blk_done", 128'(bus.blk_done), 128'(0));
      acc = bus.out_valid && bus.out_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) j++;
    end
    if (j < 16) chk("drain_timeout", 128'(j), 128'(16));
    if (v.stall) chk("stall_consumed", 128'(stall_left), 128'(0));
    bus.in_valid = 1'b0;
    chk("blk_done_pulse", 128'(bus.blk_done), 128'(1));
    chk("out_valid_after", 128'(bus.out_valid), 128'(0));
    chk("blk_valid_after", 128'(bus.blk_valid), 128'(0));
    chk("out_block_cleared", bus.out_block, 128'(0));
    chk("in_ready_after", 128'(bus.in_ready), 128'(1));
    @(posedge clk); #1;
    chk("blk_done_single", 128'(bus.blk_done), 128'(0));
  endtask

  task automatic mid_cycle_reset();
    #3 reset = 1'b1;
    #1;
    chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_blk_valid", 128'(bus.blk_valid), 128'(0));
    chk("rst_out_byte", 128'(bus.out_byte), 128'(0));
    chk("rst_out_block", bus.out_block, 128'(0));
    chk("rst_blk_done", 128'(bus.blk_done), 128'(0));
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("post_rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("post_rst_blk_done", 128'(bus.blk_done), 128'(0));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vecs[0] = '{128'h000102030405060708090A0B0C0D0E0F, 128'h00010203070405060A0B08090D0E0F0C, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{128'h10111213151617141A1B18191F1C1D1E, 128'h101112131415161718191A1B1C1D1E1F, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF, 128'hC0C1C2C3C7C4C5C6CACBC8C9CDCECFCC, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{128'h000102030405060708090A0B0C0D0E0F, 128'h00010203070405060A0B08090D0E0F0C, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{128'h000102030405060708090A0B0C0D0E0F, 128'h00010203070405060A0B08090D0E0F0C, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{128'h000102030405060708090A0B0C0D0E0F, 128'h00010203070405060A0B08090D0E0F0C, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{128'h000102030405060708090A0B0C0D0E0F, 128'h00010203070405060A0B08090D0E0F0C, 1'b0, 1'b0, 1'b0};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.out_ready = 1'b1;
    #3;
    chk("reset_in_ready", 128'(bus.in_ready), 128'(0));
    chk("reset_out_valid", 128'(bus.out_valid), 128'(0));
    chk("reset_out_block", bus.out_block, 128'(0));
    chk("reset_out_byte", 128'(bus.out_byte), 128'(0));
    chk("reset_blk_done", 128'(bus.blk_done), 128'(0));
    #9 reset = 1'b0;
    @(posedge clk); #1;
    chk("release_in_ready", 128'(bus.in_ready), 128'(1));
    chk("release_out_valid", 128'(bus.out_valid), 128'(0));
    chk("release_out_block", bus.out_block, 128'(0));

    for (int i = 0; i < int'(NV); i++) run_vec(vecs[i]);

    // Abort in DRAIN after three bytes have left.
    for (int k = 0; k < 16; k++) begin
      bus.in_valid = 1'b1;
      bus.in_byte  = 8'(k);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("abort_drain_entered", 128'(bus.out_valid), 128'(1));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    mid_cycle_reset();
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.blk_done || bus.out_valid)
        chk("abort_drain_residue", 128'({bus.blk_done, bus.out_valid}), 128'(0));
    end
    bus.out_ready = 1'b1;

    // Abort in FILL after seven bytes, then a clean block must show no residue.
    for (int k = 0; k < 7; k++) begin
      bus.in_valid = 1'b1;
      bus.in_byte  = 8'hE0 + 8'(k);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    mid_cycle_reset();
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mod_dec_inv_shifter.md
Name: mod_dec_inv_shifter

Overview:
- Decryption-side InvShiftRows stage for the AES256 core.
- Accepts one state byte per transfer, buffers a full 16-byte block and applies the inverse row rotation.
- Presents the result as a parallel block and as a byte-serial stream with valid/ready backpressure.
- Sits between the byte-serial round-key/InvSubBytes datapath and the next decryption stage. It is the exact inverse of the encryption shifter, so enc-shift followed by dec-shift returns the original block.

Parameters:
- N, 16, bytes per block; fixed at 16; any other value is unsupported.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  1  in_byte holds a valid byte.
- in_byte  input  8  serial input byte; arrival index k = 0..15 within the block.
- in_ready  output  1  block accepts input; a transfer occurs when in_valid & in_ready.
- out_valid  output  1  out_byte holds a valid byte.
- out_byte  output  8  serial output byte.
- out_ready  input  1  downstream accepts out_byte; a transfer occurs when out_valid & out_ready.
- out_block  output  16x8  parallel InvShiftRows result, index 0..15.
- blk_valid  output  1  out_block is valid (high for the whole DRAIN state).
- blk_done  output  1  one-cycle pulse on the edge after the last output byte is accepted.

Behaviour:
- One clock, clk. Reset is asynchronous and active-high.
- Reset values:
  - buffer all 0x00; wr_cnt = 0; rd_cnt = 0; state = FILL.
  - in_ready = 0 while reset is high, 1 after release.
  - out_valid = 0, blk_valid = 0, blk_done = 0.
  - out_byte = 0x00, out_block all 0x00.
- Buffer: 16-entry byte shift register buf[0..15].
  - On each input transfer, buf[i] <= buf[i+1] for i = 0..14 and buf[15] <= in_byte.
  - After 16 transfers, arrival byte k resides in buf[k].
- Inverse mapping (combinational from buf): out_block[4r+c] = buf[4r + ((c - r) mod 4)].
  - Row 0: 0, 1, 2, 3 <- buf 0, 1, 2, 3.
  - Row 1: 4, 5, 6, 7 <- buf 7, 4, 5, 6.
  - Row 2: 8, 9, 10, 11 <- buf 10, 11, 8, 9.
  - Row 3: 12, 13, 14, 15 <- buf 13, 14, 15, 12.
  - out_block is driven to 0x00 whenever blk_valid = 0.
- FSM states:
  - FILL:
    - in_ready = 1, out_valid = 0.
    - Each input transfer shifts the buffer and increments wr_cnt (4-bit).
    - The transfer with wr_cnt == 15 sets wr_cnt <= 0 and moves to DRAIN.
    - Cycles with in_valid = 0 leave all state unchanged.
  - DRAIN:
    - in_ready = 0; in_valid is ignored and the buffer is frozen.
    - out_valid = 1, blk_valid = 1, out_byte = out_block[rd_cnt].
    - Each output transfer increments rd_cnt.
    - The transfer with rd_cnt == 15 sets rd_cnt <= 0, moves to FILL and sets blk_done = 1 for exactly one cycle.
- Latency:
  - out_valid rises in the cycle after the edge that accepts the 16th input byte.
  - Minimum block period is 32 cycles (16 FILL + 16 DRAIN) with no stalls.
- Backpressure:
  - While out_valid = 1 and out_ready = 0, out_byte and rd_cnt hold.
  - out_valid never drops before the 16th output transfer.
- Boundaries:
  - wr_cnt and rd_cnt wrap 15 -> 0 only on the final transfer; there is no other wrap.
  - An input in the same cycle as the final output transfer is not accepted, because in_ready is still 0 in DRAIN.
  - reset asserted mid-FILL or mid-DRAIN aborts the block. All state returns to reset values, with no partial output and no blk_done.
  - A new block after DRAIN overwrites the stale buffer contents through normal shifting.

Test Plan:
- Reset: assert reset mid-cycle -> outputs go to reset values immediately, without waiting for a clock edge. After release in_ready = 1, out_valid = 0, out_block = 0.
- Ordered block: send 0x00..0x0F back-to-back with out_ready = 1 -> out_byte sequence is 00 01 02 03 07 04 05 06 0A 0B 08 09 0D 0E 0F 0C.
  - Same cycle checks: out_block matches the sequence; out_valid rises 1 cycle after the 16th input; blk_done pulses once after the last output.
- Round trip: feed the encryption shifter output (block 0x10..0x1F) into this block -> out_byte stream is 0x10..0x1F in order.
- Backpressure and gaps:
  - Random in_valid gaps (16 transfers over about 40 cycles) -> same result as the ordered-block case.
  - Hold out_ready = 0 for 5 cycles at rd_cnt = 6 -> out_byte = 0x05 held, no byte lost or duplicated.
- DRAIN isolation: drive in_valid = 1 with 0xFF throughout DRAIN -> in_ready = 0, output stream unchanged, next FILL starts at wr_cnt = 0.
- Reset mid-fill: accept 7 bytes, pulse reset, then send 0x00..0x0F -> output identical to the ordered-block case, no residue from the first 7 bytes.
